// File: rtl/ub_reader_pkg.sv
// Shared types and constants for the Unified Buffer read sequencer.
// Holds the FSM state encoding, the FIFO depth and the default word-width relation.
package ub_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

  // One SRAM word carries exactly one activation row.
  function automatic int word_size(input int matrix_size, input int data_bw);
    return matrix_size * data_bw;
  endfunction

endpackage

// File: rtl/ub_read_fifo.sv
// Two-entry FIFO of {last, data} that absorbs the rows returned by the SRAM.
// Push and pop may occur in the same cycle; the head is masked to zero when empty.
module ub_read_fifo
  import ub_reader_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             push_last,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic             head_last,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] data_q [FIFO_DEPTH];
  logic             last_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= push_data;
        last_q[wr_ptr_q] <= push_last;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_valid = (cnt_q != 2'd0);
  assign head_last  = head_valid & last_q[rd_ptr_q];
  assign head_data  = head_valid ? data_q[rd_ptr_q] : '0;
  assign count      = cnt_q;

  // The issue credit in the parent must make these impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (cnt_q == 2'(FIFO_DEPTH))));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rstn)
    !(pop && (cnt_q == 2'd0)));

endmodule

// File: rtl/ctrl_ub_reader.sv
// Unified Buffer read sequencer: streams num_rows rows from base_addr onto a
// valid/ready interface, hiding the SRAM's one-cycle read latency.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// RUN   | issuing reads, limited by FIFO credit
// DRAIN | all reads issued; waiting for the last-tagged row to be accepted
module ctrl_ub_reader
  import ub_reader_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = 8,
  parameter int DATA_BW     = 8,
  parameter int WORDSIZE    = word_size(MATRIX_SIZE, DATA_BW)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE-1:0] num_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   ub_write_enable,
  output logic [ADDRESSSIZE-1:0] ub_address,
  input  logic [WORDSIZE-1:0]    ub_data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDSIZE-1:0]    out_data,
  output logic                   out_last
);

  localparam logic [ADDRESSSIZE-1:0] ONE = ADDRESSSIZE'(1);

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] num_q;
  logic [ADDRESSSIZE-1:0] issue_cnt_q;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic                   inflight_q;
  logic                   inflight_last_q;
  logic                   done_q;
  logic [1:0]             fifo_count;

  logic pop;
  logic credit_ok;
  logic accept;
  logic issue;
  logic last_issue;
  logic done_d;

  assign pop       = out_valid & out_ready;
  // Rows already buffered plus the one in the SRAM pipe must not exceed the FIFO.
  assign credit_ok = (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (num_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        issue      = credit_ok | pop;
        last_issue = issue & (issue_cnt_q == (num_q - ONE));
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_q           <= '0;
      issue_cnt_q     <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      done_q          <= done_d;
      if (accept) begin
        num_q       <= num_rows;
        issue_cnt_q <= '0;
        if (num_rows != '0) begin
          addr_q <= base_addr;
        end
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + ONE;
        // The address register always shows the read being issued, so it
        // advances only while more rows remain and otherwise holds.
        if (!last_issue) begin
          addr_q <= addr_q + ONE;
        end
      end
    end
  end

  ub_read_fifo #(
    .WIDTH(WORDSIZE)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight_q),
    .push_last (inflight_last_q),
    .push_data (ub_data_out),
    .pop       (pop),
    .head_valid(out_valid),
    .head_last (out_last),
    .head_data (out_data),
    .count     (fifo_count)
  );

  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign ub_write_enable = 1'b0;
  assign ub_address      = addr_q;

endmodule

// File: tb/tb_ctrl_ub_reader.sv
// Self-checking bench for ctrl_ub_reader: command table, random commands and
// hand-written reset/back-to-back sequences against a row-queue reference model.
module tb_ctrl_ub_reader;

  localparam int AW = 10;
  localparam int WS = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_rows = '0;
  logic          busy, done, ub_write_enable;
  logic [AW-1:0] ub_address;
  logic [WS-1:0] ub_data_out = '0;
  logic          out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [WS-1:0] out_data;

  logic [WS-1:0] mem [1024];
  int total = 0;
  int bad   = 0;

  ctrl_ub_reader #(
    .ADDRESSSIZE(AW),
    .MATRIX_SIZE(8),
    .DATA_BW    (8)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .base_addr      (base_addr),
    .num_rows       (num_rows),
    .busy           (busy),
    .done           (done),
    .ub_write_enable(ub_write_enable),
    .ub_address     (ub_address),
    .ub_data_out    (ub_data_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data for an address appears the cycle after it.
  always @(posedge clk) ub_data_out <= mem[ub_address];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] n;
    int            mode;      // 0: ready=1, 1: ready 1,0,0,..., 2: random ready
    bit            poke;      // drive a stray start while busy
    int            exp_done;  // cycle index of done after start, -1 if ready-dependent
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_addr"}, ub_address, 0);
    chk({tag, "_we"}, ub_write_enable, 0);
    chk({tag, "_fifo_count"}, dut.fifo_count, 0);
  endtask

  // Called at a falling edge; returns at the falling edge where done is high.
  task automatic run_cmd(input logic [AW-1:0] base, input logic [AW-1:0] n,
                         input int mode, input bit poke, input int exp_done);
    logic [WS-1:0] exp_q[$];
    logic [WS-1:0] pd;
    logic [AW-1:0] addr0, ea;
    logic          pv, pr, pl;
    int            done_k, first_k;
    bit            finished;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[(int'(base) + i) % 1024]);
    done_k   = (n == 0) ? 0 : -1;
    first_k  = -1;
    addr0    = ub_address;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    finished = 1'b0;
    start     = 1'b1;
    base_addr = base;
    num_rows  = n;
    out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 400 && !finished; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (poke && k == 1) begin
        start = 1'b1; base_addr = ~base; num_rows = 10'd3;
      end
      if (poke && k == 2) start = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      chk("write_enable", ub_write_enable, 0);
      chk("fifo_count_bound", (dut.fifo_count <= 2), 1);
      if (n == 0) begin
        chk("zero_busy", busy, 0);
        chk("zero_valid", out_valid, 0);
        if (k == 0) chk("zero_addr_held", ub_address, addr0);
      end else if (k == 0) begin
        chk("busy_after_start", busy, 1);
      end
      if (mode == 0 && k < int'(n)) begin
        ea = base + AW'(k);
        chk("addr_seq", ub_address, ea);
      end
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_last", out_last, pl);
      end
      if (out_valid && first_k < 0) begin
        first_k = k;
        if (mode == 0) chk("first_valid_latency", k, 2);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_row", out_valid, 0);
        end else begin
          chk("row_data", out_data, exp_q[0]);
          chk("row_last", out_last, (exp_q.size() == 1));
          if (exp_q.size() == 1) done_k = k + 1;
          void'(exp_q.pop_front());
        end
      end
      if (k == done_k) begin
        chk("done_pulse", done, 1);
        chk("idle_at_done", busy, 0);
        finished = 1'b1;
      end else begin
        chk("no_early_done", done, 0);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL timeout: done not seen, rows left %0d", exp_q.size());
    end else begin
      chk("rows_remaining", exp_q.size(), 0);
      if (exp_done >= 0) chk("done_cycle", done_k, exp_done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};

    vecs[0] = '{10'h010, 10'd4,  0, 1'b0, 6};   // basic stream
    vecs[1] = '{10'h3FE, 10'd4,  0, 1'b0, 6};   // address wrap
    vecs[2] = '{10'h020, 10'd6,  1, 1'b0, -1};  // backpressure 1,0,0
    vecs[3] = '{10'h0AB, 10'd0,  0, 1'b0, 0};   // zero length
    vecs[4] = '{10'h055, 10'd5,  0, 1'b1, 7};   // stray start while busy
    vecs[5] = '{10'h100, 10'd2,  0, 1'b0, 4};   // back-to-back on done cycle
    vecs[6] = '{10'h200, 10'd1,  0, 1'b0, 3};
    vecs[7] = '{10'h3FF, 10'd7,  2, 1'b0, -1};
    vecs[8] = '{10'h2AA, 10'd10, 2, 1'b1, -1};

    #2 rstn = 1'b0;
    #1 check_reset_vals("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    // Each command starts on the falling edge where the previous done is seen.
    for (int v = 0; v < 9; v++)
      run_cmd(vecs[v].base, vecs[v].n, vecs[v].mode, vecs[v].poke, vecs[v].exp_done);

    // Reset while the third row of an 8-row command is presented.
    @(negedge clk);
    start = 1'b1; base_addr = 10'h080; num_rows = 10'd8; out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    chk("pre_reset_row3_valid", out_valid, 1);
    chk("pre_reset_row3_data", out_data, mem[10'h082]);
    rstn = 1'b0;
    #1 check_reset_vals("mid_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_no_done", done, 0);
    end
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("after_reset_no_done", done, 0);
      chk("after_reset_no_valid", out_valid, 0);
    end
    run_cmd(10'h0C0, 10'd2, 0, 1'b0, 4);

    for (int r = 0; r < 8; r++)
      run_cmd(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 9)), 2, 1'b0, -1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
